// File: rtl/pipe_stage_reg.sv
// Handshaked stage register, optional 2-entry skid buffer, sync flush; 1-cycle latency, 1 beat/cycle.
// Backpressure: in_ready from inverted skid-valid flop (SKID_EN=1) or out_ready|~out_valid (SKID_EN=0).
module pipe_stage_reg #(
    parameter int DATA_W       = 32,
    parameter bit SKID_EN      = 1'b1,
    parameter bit CLR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    if (SKID_EN) begin : g_skid
        typedef enum logic [1:0] {
            EMPTY = 2'd0,
            ONE   = 2'd1,
            FULL  = 2'd2
        } state_t;

        state_t            state;
        logic [DATA_W-1:0] main_dat;
        logic [DATA_W-1:0] skid_dat;
        logic              main_vld;
        logic              skid_vld;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state    <= EMPTY;
                main_dat <= '0;
                skid_dat <= '0;
                main_vld <= 1'b0;
                skid_vld <= 1'b0;
            end else if (flush) begin
                // Flush wins over any beat offered or drained this cycle.
                state    <= EMPTY;
                main_vld <= 1'b0;
                skid_vld <= 1'b0;
                if (CLR_ON_FLUSH) begin
                    main_dat <= '0;
                    skid_dat <= '0;
                end
            end else begin
                case (state)
                    EMPTY: begin
                        if (in_xfer) begin
                            main_dat <= in_data;
                            main_vld <= 1'b1;
                            state    <= ONE;
                        end
                    end
                    ONE: begin
                        if (in_xfer && out_xfer) begin
                            main_dat <= in_data;
                        end else if (in_xfer) begin
                            skid_dat <= in_data;
                            skid_vld <= 1'b1;
                            state    <= FULL;
                        end else if (out_xfer) begin
                            main_vld <= 1'b0;
                            state    <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (out_xfer) begin
                            main_dat <= skid_dat;
                            skid_vld <= 1'b0;
                            state    <= ONE;
                        end
                    end
                    default: begin
                        state    <= EMPTY;
                        main_vld <= 1'b0;
                        skid_vld <= 1'b0;
                    end
                endcase
            end
        end

        assign in_ready  = ~skid_vld;
        assign out_valid = main_vld;
        assign out_data  = main_dat;
        assign occupancy = {skid_vld, main_vld & ~skid_vld};
    end else begin : g_single
        logic [DATA_W-1:0] main_dat;
        logic              main_vld;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                main_dat <= '0;
                main_vld <= 1'b0;
            end else if (flush) begin
                main_vld <= 1'b0;
                if (CLR_ON_FLUSH) begin
                    main_dat <= '0;
                end
            end else if (in_xfer) begin
                main_dat <= in_data;
                main_vld <= 1'b1;
            end else if (out_xfer) begin
                main_vld <= 1'b0;
            end
        end

        assign in_ready  = out_ready | ~main_vld;
        assign out_valid = main_vld;
        assign out_data  = main_dat;
        assign occupancy = {1'b0, main_vld};
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: skid instance (32-bit, clear on flush) and single-register instance (8-bit, keep on flush).
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset;

    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    logic        flush0;
    logic        in_valid0;
    logic        in_ready0;
    logic [7:0]  in_data0;
    logic        out_valid0;
    logic        out_ready0;
    logic [7:0]  out_data0;
    logic [1:0]  occupancy0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .SKID_EN(1'b1), .CLR_ON_FLUSH(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    pipe_stage_reg #(.DATA_W(8), .SKID_EN(1'b0), .CLR_ON_FLUSH(1'b0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush0),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .in_data   (in_data0),
        .out_valid (out_valid0),
        .out_ready (out_ready0),
        .out_data  (out_data0),
        .occupancy (occupancy0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        flush0     = 1'b0;
        in_valid0  = 1'b0;
        in_data0   = '0;
        out_ready0 = 1'b0;

        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst0_in_ready", 32'(in_ready0), 32'd1);
        chk("rst0_out_valid", 32'(out_valid0), 32'd0);

        step();
        step();
        reset = 1'b1;

        // Streaming with out_ready high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        #1;
        chk("s_in_ready0", 32'(in_ready), 32'd1);
        step();
        chk("s_data11", out_data, 32'h11);
        chk("s_valid11", 32'(out_valid), 32'd1);
        chk("s_occ11", 32'(occupancy), 32'd1);
        in_data = 32'h22;
        chk("s_in_ready1", 32'(in_ready), 32'd1);
        step();
        chk("s_data22", out_data, 32'h22);
        chk("s_occ22", 32'(occupancy), 32'd1);
        in_data = 32'h33;
        chk("s_in_ready2", 32'(in_ready), 32'd1);
        step();
        chk("s_data33", out_data, 32'h33);
        chk("s_occ33", 32'(occupancy), 32'd1);
        in_valid = 1'b0;
        step();
        chk("s_drain_valid", 32'(out_valid), 32'd0);
        chk("s_drain_occ", 32'(occupancy), 32'd0);

        // Backpressure fill and drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA5;
        step();
        chk("bp_occ1", 32'(occupancy), 32'd1);
        chk("bp_in_ready1", 32'(in_ready), 32'd1);
        chk("bp_data1", out_data, 32'hA5);
        in_data = 32'h5A;
        step();
        chk("bp_occ2", 32'(occupancy), 32'd2);
        chk("bp_in_ready2", 32'(in_ready), 32'd0);
        chk("bp_data2", out_data, 32'hA5);
        in_valid = 1'b0;
        in_data  = 32'hDEAD;
        step();
        chk("bp_hold_data", out_data, 32'hA5);
        chk("bp_hold_occ", 32'(occupancy), 32'd2);
        out_ready = 1'b1;
        step();
        chk("bp_drain1_data", out_data, 32'h5A);
        chk("bp_drain1_occ", 32'(occupancy), 32'd1);
        chk("bp_drain1_rdy", 32'(in_ready), 32'd1);
        step();
        chk("bp_drain2_valid", 32'(out_valid), 32'd0);
        chk("bp_drain2_occ", 32'(occupancy), 32'd0);

        // Simultaneous in/out while holding one beat
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h01;
        step();
        chk("sim_data01", out_data, 32'h01);
        in_data   = 32'h02;
        out_ready = 1'b1;
        step();
        chk("sim_data02", out_data, 32'h02);
        chk("sim_valid", 32'(out_valid), 32'd1);
        chk("sim_occ", 32'(occupancy), 32'd1);
        in_valid = 1'b0;
        step();
        chk("sim_drain", 32'(out_valid), 32'd0);

        // Flush while FULL with a beat offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h10;
        step();
        in_data = 32'h20;
        step();
        chk("fl_pre_occ", 32'(occupancy), 32'd2);
        flush   = 1'b1;
        in_data = 32'hFF;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_occ", 32'(occupancy), 32'd0);
        chk("fl_data", out_data, 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        step();
        chk("fl_no_ff", 32'(out_valid), 32'd0);

        // Flush while ONE with in_ready high: offered beat must still be dropped
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h30;
        step();
        flush   = 1'b1;
        in_data = 32'hEE;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl1_valid", 32'(out_valid), 32'd0);
        chk("fl1_occ", 32'(occupancy), 32'd0);
        step();
        chk("fl1_no_ee", 32'(out_valid), 32'd0);

        // Async reset while FULL, between edges
        in_valid = 1'b1;
        in_data  = 32'h40;
        step();
        in_data = 32'h50;
        step();
        in_valid = 1'b0;
        chk("ar_pre_occ", 32'(occupancy), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_occ", 32'(occupancy), 32'd0);
        chk("ar_data", out_data, 32'd0);
        chk("ar_in_ready", 32'(in_ready), 32'd1);
        step();
        reset     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h77;
        step();
        in_valid = 1'b0;
        chk("ar_data77", out_data, 32'h77);
        chk("ar_occ77", 32'(occupancy), 32'd1);
        step();
        chk("ar_alone", 32'(out_valid), 32'd0);
        chk("ar_alone_occ", 32'(occupancy), 32'd0);

        // Single-register variant
        out_ready0 = 1'b0;
        in_valid0  = 1'b1;
        in_data0   = 8'hAB;
        #1;
        chk("s0_rdy_empty", 32'(in_ready0), 32'd1);
        step();
        chk("s0_dataAB", 32'(out_data0), 32'hAB);
        chk("s0_occ", 32'(occupancy0), 32'd1);
        in_data0 = 8'hCD;
        #1;
        chk("s0_rdy_stall", 32'(in_ready0), 32'd0);
        out_ready0 = 1'b1;
        #1;
        chk("s0_rdy_comb", 32'(in_ready0), 32'd1);
        step();
        chk("s0_dataCD", 32'(out_data0), 32'hCD);
        chk("s0_validCD", 32'(out_valid0), 32'd1);
        in_valid0  = 1'b0;
        out_ready0 = 1'b0;
        in_data0   = 8'h99;
        step();
        chk("s0_hold", 32'(out_data0), 32'hCD);
        flush0    = 1'b1;
        in_valid0 = 1'b1;
        in_data0  = 8'hEE;
        step();
        flush0    = 1'b0;
        in_valid0 = 1'b0;
        chk("s0_fl_valid", 32'(out_valid0), 32'd0);
        chk("s0_fl_occ", 32'(occupancy0), 32'd0);
        chk("s0_fl_keep", 32'(out_data0), 32'hCD);
        chk("s0_fl_rdy", 32'(in_ready0), 32'd1);
        in_valid0 = 1'b1;
        in_data0  = 8'h12;
        step();
        in_valid0  = 1'b0;
        out_ready0 = 1'b1;
        chk("s0_data12", 32'(out_data0), 32'h12);
        step();
        chk("s0_drain", 32'(out_valid0), 32'd0);
        chk("s0_drain_occ", 32'(occupancy0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
